// File: rtl/spi_slave_receiver_if.sv
// spi_slave_receiver_if
//   Consumer-side bundle of the SPI slave receiver.
//   slave  modport : the receiver (drives word, valid and status pulses)
//   master modport : the consumer (drives rx_ready)
// Signals:
//   rx_data   [WORD_WIDTH] received word, meaningful while rx_valid
//   rx_valid  word available
//   rx_ready  consumer accepts on rx_valid && rx_ready
//   overrun   1-cycle pulse, completed word dropped
//   frame_err 1-cycle pulse, ss_n released mid-word
//   busy      synchronised slave select is active
interface spi_slave_receiver_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  overrun;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    output rx_data, rx_valid, overrun, frame_err, busy,
    input  rx_ready
  );

  modport master (
    input  rx_data, rx_valid, overrun, frame_err, busy,
    output rx_ready
  );
endinterface

// File: rtl/spi_slave_receiver.sv
// spi_slave_receiver
//   SPI mode-0 slave deserialiser. ss_n/sclk/mosi are synchronised into the
//   clock domain, words are assembled MSB first and handed out over a
//   valid/ready interface. Several words per ss_n frame are supported.
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   ss_n   slave select (async, active low)
//   sclk   serial clock (async)
//   mosi   serial data (async)
//   rx_if  spi_slave_receiver_if.slave: rx_data/rx_valid/rx_ready,
//          overrun, frame_err, busy
// Build option:
//   SPI_RX_FIFO_EN  when defined, completed words go through a FIFO_DEPTH
//                   entry first-word-fall-through FIFO instead of a single
//                   holding register.
module spi_slave_receiver #(
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ss_n,
  input  logic                 sclk,
  input  logic                 mosi,
  spi_slave_receiver_if.slave  rx_if
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Pin synchronisers, bit order {ss_n, sclk, mosi}; idle levels on reset.
  logic [2:0] pin_in;
  logic [2:0] sync1_reg, sync2_reg;
  logic       ss_d_reg, sclk_d_reg;
  logic [1:0] flush_reg;
  logic       armed_reg;

  assign pin_in = {ss_n, sclk, mosi};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg  <= 3'b100;
      sync2_reg  <= 3'b100;
      ss_d_reg   <= 1'b1;
      sclk_d_reg <= 1'b0;
      flush_reg  <= 2'b00;
      armed_reg  <= 1'b0;
    end else begin
      sync1_reg  <= pin_in;
      sync2_reg  <= sync1_reg;
      ss_d_reg   <= sync2_reg[2];
      sclk_d_reg <= sync2_reg[1];
      flush_reg  <= {flush_reg[0], 1'b1};
      // Arm only once ss_n has been seen high through a flushed synchroniser,
      // so a reset released mid-frame cannot fake a falling edge.
      armed_reg  <= armed_reg | (flush_reg[1] & sync2_reg[2]);
    end
  end

  logic ss_s, sclk_s, mosi_s;
  logic sclk_rise, ss_fall, ss_rise;

  assign ss_s      = sync2_reg[2];
  assign sclk_s    = sync2_reg[1];
  assign mosi_s    = sync2_reg[0];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign ss_fall   = ~ss_s & ss_d_reg & armed_reg;
  assign ss_rise   = ss_s & ~ss_d_reg;

  // Framing FSM
  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [WORD_WIDTH-1:0] shift_reg, shift_next;
  logic                  word_done_reg, word_done_next;
  logic                  frame_err_reg, frame_err_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      word_done_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      word_done_reg <= word_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    word_done_next = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          shift_next   = '0;
        end
      end
      SHIFT: begin
        // ss_n release wins over a coincident sclk edge.
        if (ss_rise) begin
          state_next     = IDLE;
          frame_err_next = (bit_cnt_reg != '0);
          bit_cnt_next   = '0;
          shift_next     = '0;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[WORD_WIDTH-2:0], mosi_s};
          if (bit_cnt_reg == CNT_LAST) begin
            bit_cnt_next   = '0;
            word_done_next = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // word_done_reg is high the cycle after the last bit lands, when shift_reg
  // holds the complete word; the next sclk rise is several cycles away.
  logic overrun_reg;

`ifdef SPI_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_reg, rd_ptr_reg;
  logic                  fifo_empty, fifo_full, pop, push_ok;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign pop        = ~fifo_empty & rx_if.rx_ready;
  assign push_ok    = word_done_reg & (~fifo_full | pop);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_reg[PTR_W-1:0]] <= shift_reg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      overrun_reg <= word_done_reg & ~push_ok;
    end
  end

  // Head entry falls through; zero while empty so reset shows rx_data = 0.
  assign rx_if.rx_valid = ~fifo_empty;
  assign rx_if.rx_data  = fifo_empty ? '0 : mem[rd_ptr_reg[PTR_W-1:0]];
`else
  logic [WORD_WIDTH-1:0] data_reg;
  logic                  valid_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (word_done_reg) begin
        // Accept when empty or when the held word is popped this cycle.
        if (!valid_reg || rx_if.rx_ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && rx_if.rx_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_if.rx_valid = valid_reg;
  assign rx_if.rx_data  = data_reg;
`endif

  assign rx_if.overrun   = overrun_reg;
  assign rx_if.frame_err = frame_err_reg;
  assign rx_if.busy      = armed_reg & ~ss_s;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb_spi_slave_receiver
//   Directed bench for spi_slave_receiver (WORD_WIDTH = 8). SPI pins are
//   driven on the falling clock edge with a 4-cycle sclk half-period; DUT
//   outputs are checked on the falling edge. Popped words, overrun and
//   frame_err cycles are recorded at the rising edge where they take effect.
module tb_spi_slave_receiver;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ss_n  = 1'b1;
  logic sclk  = 1'b0;
  logic mosi  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  spi_slave_receiver_if #(.WORD_WIDTH(8)) rx_if ();

  spi_slave_receiver #(.WORD_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .ss_n  (ss_n),
    .sclk  (sclk),
    .mosi  (mosi),
    .rx_if (rx_if)
  );

  always #5 clock = ~clock;

  // Recorders
  logic [7:0] rec_q[$];
  int         ovr_cnt  = 0;
  int         ferr_cnt = 0;

  always @(posedge clock) begin
    if (rx_if.rx_valid && rx_if.rx_ready) rec_q.push_back(rx_if.rx_data);
    if (rx_if.overrun)   ovr_cnt++;
    if (rx_if.frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (4) @(negedge clock);
    sclk = 1'b1;
    repeat (4) @(negedge clock);
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) spi_bit(w[i]);
  endtask

  task automatic start_frame();
    @(negedge clock);
    ss_n = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clock);
    ss_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  int base_rec, base_ovr, base_ferr;

  initial begin
    rx_if.rx_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clock);
    check("reset_valid",   32'(rx_if.rx_valid),  32'h0);
    check("reset_data",    32'(rx_if.rx_data),   32'h0);
    check("reset_overrun", 32'(rx_if.overrun),   32'h0);
    check("reset_ferr",    32'(rx_if.frame_err), 32'h0);
    check("reset_busy",    32'(rx_if.busy),      32'h0);
    reset = 1'b1;
    repeat (6) @(negedge clock);

    // ---- single word 0xA5 with exact latency ----
    base_rec = rec_q.size(); base_ovr = ovr_cnt; base_ferr = ferr_cnt;
    start_frame();
    check("a5_busy", 32'(rx_if.busy), 32'h1);
    for (int i = 7; i >= 1; i--) spi_bit(((8'hA5 >> i) & 8'h01) != 0);
    mosi = 1'b1;
    repeat (4) @(negedge clock);
    sclk = 1'b1;
    repeat (3) @(negedge clock);
    check("a5_valid_edge3", 32'(rx_if.rx_valid), 32'h0);
    @(negedge clock);
    check("a5_valid_edge4", 32'(rx_if.rx_valid), 32'h1);
    check("a5_data_edge4",  32'(rx_if.rx_data),  32'hA5);
    @(negedge clock);
    check("a5_valid_edge5", 32'(rx_if.rx_valid), 32'h0);
    @(negedge clock);
    sclk = 1'b0;
    end_frame();
    check("a5_pops",    32'(rec_q.size() - base_rec), 32'h1);
    check("a5_word",    32'(rec_q[base_rec]),         32'hA5);
    check("a5_overrun", 32'(ovr_cnt - base_ovr),      32'h0);
    check("a5_ferr",    32'(ferr_cnt - base_ferr),    32'h0);
    check("a5_busy_off", 32'(rx_if.busy),             32'h0);

    // ---- multi-word frame 0x12 0x34 0x56 ----
    base_rec = rec_q.size(); base_ferr = ferr_cnt;
    start_frame();
    send_word(8'h12);
    check("multi_busy1", 32'(rx_if.busy), 32'h1);
    send_word(8'h34);
    check("multi_busy2", 32'(rx_if.busy), 32'h1);
    send_word(8'h56);
    repeat (4) @(negedge clock);
    check("multi_busy3", 32'(rx_if.busy), 32'h1);
    end_frame();
    check("multi_pops", 32'(rec_q.size() - base_rec), 32'h3);
    if (rec_q.size() - base_rec == 3) begin
      check("multi_w0", 32'(rec_q[base_rec]),     32'h12);
      check("multi_w1", 32'(rec_q[base_rec + 1]), 32'h34);
      check("multi_w2", 32'(rec_q[base_rec + 2]), 32'h56);
    end
    check("multi_ferr", 32'(ferr_cnt - base_ferr), 32'h0);

    // ---- frame error after 5 bits, then 0xC3 ----
    base_rec = rec_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt;
    start_frame();
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    end_frame();
    check("ferr_pulse",  32'(ferr_cnt - base_ferr),      32'h1);
    check("ferr_nopush", 32'(rec_q.size() - base_rec),   32'h0);
    check("ferr_valid",  32'(rx_if.rx_valid),            32'h0);
    start_frame();
    send_word(8'hC3);
    end_frame();
    check("c3_pops", 32'(rec_q.size() - base_rec), 32'h1);
    if (rec_q.size() - base_rec == 1) check("c3_word", 32'(rec_q[base_rec]), 32'hC3);
    check("c3_ferr", 32'(ferr_cnt - base_ferr), 32'h1);
    check("c3_ovr",  32'(ovr_cnt - base_ovr),   32'h0);

    // ---- back-pressure ----
    base_rec = rec_q.size(); base_ovr = ovr_cnt;
    @(negedge clock);
    rx_if.rx_ready = 1'b0;
`ifdef SPI_RX_FIFO_EN
    start_frame();
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    check("bp_ovr_4", 32'(ovr_cnt - base_ovr), 32'h0);
    send_word(8'h55);
    end_frame();
    check("bp_ovr",   32'(ovr_cnt - base_ovr), 32'h1);
    check("bp_valid", 32'(rx_if.rx_valid),     32'h1);
    check("bp_head",  32'(rx_if.rx_data),      32'h11);
    rx_if.rx_ready = 1'b1;
    repeat (8) @(negedge clock);
    check("bp_pops", 32'(rec_q.size() - base_rec), 32'h4);
    if (rec_q.size() - base_rec == 4) begin
      check("bp_w0", 32'(rec_q[base_rec]),     32'h11);
      check("bp_w1", 32'(rec_q[base_rec + 1]), 32'h22);
      check("bp_w2", 32'(rec_q[base_rec + 2]), 32'h33);
      check("bp_w3", 32'(rec_q[base_rec + 3]), 32'h44);
    end
`else
    start_frame();
    send_word(8'h11);
    send_word(8'h22);
    end_frame();
    check("bp_ovr",   32'(ovr_cnt - base_ovr), 32'h1);
    check("bp_valid", 32'(rx_if.rx_valid),     32'h1);
    check("bp_data",  32'(rx_if.rx_data),      32'h11);
    rx_if.rx_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("bp_pops", 32'(rec_q.size() - base_rec), 32'h1);
    if (rec_q.size() - base_rec == 1) check("bp_w0", 32'(rec_q[base_rec]), 32'h11);
    check("bp_drained", 32'(rx_if.rx_valid), 32'h0);
`endif
    check("bp_ovr_final", 32'(ovr_cnt - base_ovr), 32'h1);

    // ---- reset mid-frame, then 0x7E ----
    base_rec = rec_q.size(); base_ovr = ovr_cnt; base_ferr = ferr_cnt;
    start_frame();
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid",   32'(rx_if.rx_valid),  32'h0);
    check("rst_data",    32'(rx_if.rx_data),   32'h0);
    check("rst_busy",    32'(rx_if.busy),      32'h0);
    check("rst_overrun", 32'(rx_if.overrun),   32'h0);
    check("rst_ferr",    32'(rx_if.frame_err), 32'h0);
    spi_bit(1'b1);
    reset = 1'b1;
    spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    check("rst_busy_after",  32'(rx_if.busy),                32'h0);
    check("rst_valid_after", 32'(rx_if.rx_valid),            32'h0);
    check("rst_nopush",      32'(rec_q.size() - base_rec),   32'h0);
    end_frame();
    check("rst_no_ferr", 32'(ferr_cnt - base_ferr), 32'h0);
    start_frame();
    check("7e_busy", 32'(rx_if.busy), 32'h1);
    send_word(8'h7E);
    end_frame();
    check("7e_pops", 32'(rec_q.size() - base_rec), 32'h1);
    if (rec_q.size() - base_rec == 1) check("7e_word", 32'(rec_q[base_rec]), 32'h7E);
    check("7e_ovr",  32'(ovr_cnt - base_ovr),   32'h0);
    check("7e_ferr", 32'(ferr_cnt - base_ferr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_receiver.md
# spi_slave_receiver

Deserialising receiver downstream of `spi_master`. It consumes `ss_n`/`sclk`/`mosi` and synchronises them into the system `clock` domain. It assembles MSB-first words and hands them to the system through a valid/ready interface. Optional buffering absorbs back-pressure, and framing faults and overruns are reported as one-cycle pulses.

## Interface
- `WORD_WIDTH`, default 8: bits per received word; legal range 2–32.
- `FIFO_DEPTH`, default 4: entries in the receive FIFO; must be a power of two ≥ 2; ignored unless `SPI_RX_FIFO_EN` is defined.
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `ss_n` in 1: slave select from the master, active-low, asynchronous to `clock`.
- `sclk` in 1: serial clock from the master, asynchronous to `clock`.
- `mosi` in 1: serial data from the master, asynchronous to `clock`.
- `rx_data` out `WORD_WIDTH`: received word; valid while `rx_valid` is high.
- `rx_valid` out 1: a word is available.
- `rx_ready` in 1: consumer accepts the word on any cycle with `rx_valid && rx_ready`.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `frame_err` out 1: one-cycle pulse when `ss_n` deasserts mid-word.
- `busy` out 1: high while the synchronised `ss_n` is low.

## Operation
- **Synchronisers:** `ss_n`, `sclk` and `mosi` each pass through a 2-flop synchroniser. A third flop on `sclk` and on `ss_n` provides edge detection.
- **SPI mode:** mode 0, MSB first. `mosi` is sampled on the synchronised `sclk` rising edge; `sclk` falling edges are ignored.
- **FSM state IDLE:** `ss_n` high, `bit_cnt` = 0, `sclk` edges ignored.
  - Synchronised `ss_n` falling edge → SHIFT.
- **FSM state SHIFT:** each `sclk` rising edge shifts `mosi` into `shift_reg[0]`, shifting left, and increments `bit_cnt`.
  - When `bit_cnt` reaches `WORD_WIDTH-1` and a rising edge occurs, the completed word is pushed and `bit_cnt` wraps to 0.
  - The FSM stays in SHIFT, so several words per frame are supported.
- **SHIFT exit:** synchronised `ss_n` rising edge → IDLE.
  - If `bit_cnt` ≠ 0 at that point, `frame_err` pulses for 1 cycle and the partial word is discarded.
  - `bit_cnt` and `shift_reg` clear in either case.
- **Simultaneous edges:** if an `sclk` rising edge and an `ss_n` rising edge are detected in the same cycle, the `sclk` edge is ignored.
- **Push/pop (base build, no FIFO):** a single holding register is used.
  - A push is accepted if `!rx_valid`, or if `rx_ready` is high in the same cycle (simultaneous pop and push).
  - Otherwise the new word is dropped, the held word is kept, and `overrun` pulses.
- **Reset (async assert):** reset takes effect immediately, including mid-frame.
  - Values on reset: `rx_valid` = 0, `rx_data` = 0, `overrun` = 0, `frame_err` = 0, `busy` = 0.
  - Synchronisers reset to `ss_n` = 1, `sclk` = 0, `mosi` = 0. The FSM goes to IDLE and the counters clear.
- **Mid-frame reset release:** after reset releases during an active frame, the FSM waits for a fresh `ss_n` falling edge. `sclk` edges are ignored until then.

## Timing
- **Edge detection:** a pin-level `sclk` rising edge is acted on at the 3rd `clock` rising edge after it (2 synchroniser stages plus the edge register).
- **Pin to valid:** `rx_valid` goes high at the 4th `clock` edge after the `sclk` rising edge of the word's last bit.
- **Minimum `sclk` rate:** `sclk` high and low phases must each be ≥ 3 `clock` periods; `mosi` must be stable for ≥ 3 `clock` periods around the `sclk` rising edge.
- **`busy` timing:** `busy` follows `ss_n` with 2 cycles of latency.
- **Pulse timing:** `frame_err` and `overrun` are registered and high for exactly 1 cycle.
- **Handshake:** `rx_data` is held stable while `rx_valid && !rx_ready`. `rx_valid` deasserts the cycle after the pop unless another word is available.

## Configuration
- **`SPI_RX_FIFO_EN` defined:** completed words enter a `FIFO_DEPTH`-entry FIFO.
  - `rx_data` and `rx_valid` present the head entry (first-word fall-through).
  - A push while full is accepted only if a pop occurs in the same cycle; otherwise the word is dropped and `overrun` pulses.
  - Pointers wrap modulo `FIFO_DEPTH`; an extra pointer bit distinguishes full from empty.
- **`SPI_RX_FIFO_EN` undefined:** the single holding register described in Operation is used; `FIFO_DEPTH` is unused.

## Test plan
- **Single word:** frame 0xA5 at `WORD_WIDTH`=8, `sclk` half-period 4 cycles, `rx_ready`=1 → `rx_valid` high for 1 cycle with `rx_data`=0xA5 at the 4th edge after the 8th `sclk` rise; no `overrun`, no `frame_err`.
- **Multi-word frame:** 0x12, 0x34, 0x56 in one `ss_n` frame, `rx_ready`=1 → three pops in that order; `busy` high for the whole frame.
- **Frame error:** `ss_n` raised after 5 bits → `frame_err` pulses once, no word is pushed; the next full frame of 0xC3 is received correctly.
- **Back-pressure, no FIFO:** `rx_ready`=0, two words 0x11 then 0x22 → `overrun` pulses once and `rx_data` stays 0x11. With `SPI_RX_FIFO_EN` and `FIFO_DEPTH`=4, five words with `rx_ready`=0 → `overrun` pulses on the 5th word and words 1–4 drain in order.
- **Reset mid-frame:** pulse `reset` low after 3 bits while `sclk` continues → all outputs 0 and `sclk` ignored until the next `ss_n` falling edge; a subsequent frame of 0x7E is received intact.
